// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end: assembles big-endian 32-bit words from a byte-wide
// synchronous instruction memory and queues them with their PC for the core.
module imem_fetch_unit #(
  parameter int          ADDR_W   = 5,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [31:0]       fetch_pc_r;
  logic [1:0]        byte_idx_r;
  logic              mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              iss_last_r;
  logic [31:0]       iss_pc_r;
  logic              ret_valid_r;
  logic              ret_last_r;
  logic [31:0]       ret_pc_r;
  logic [23:0]       asm_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  inflight_r;
  logic [CNT_W-1:0]  pending_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [31:0]       fifo_word_r [DEPTH];
  logic [31:0]       fifo_pc_r   [DEPTH];
  logic              fault_r;
  logic              misaligned_s;
  logic              issue_s;
  logic              start_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       push_word_s;

  // Issue, push and pop decisions; pending counts stored plus in-flight words.
  always_comb begin
    misaligned_s = (redirect_pc[1:0] != 2'b00);
    pending_s    = cnt_r + inflight_r;
    issue_s      = 1'b0;
    if ((state_r == FETCH) && !redirect) begin
      issue_s = (byte_idx_r != 2'd0) || (pending_s < DEPTH_C);
    end else begin
      issue_s = 1'b0;
    end
    start_s     = issue_s && (byte_idx_r == 2'd0);
    push_s      = ret_valid_r && ret_last_r && !redirect;
    pop_s       = (cnt_r != CNT_ZERO) && inst_ready && !redirect;
    push_word_s = {asm_r, mem_data};
  end

  // Next-state logic: any redirect decides between resuming fetch and halting.
  always_comb begin
    state_next_s = state_r;
    if (redirect) begin
      if (misaligned_s) begin
        state_next_s = HALT;
      end else begin
        state_next_s = FETCH;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetch sequencing, byte return pipeline, assembly and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r  <= RESET_PC;
      byte_idx_r  <= 2'd0;
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      iss_last_r  <= 1'b0;
      iss_pc_r    <= 32'h0000_0000;
      ret_valid_r <= 1'b0;
      ret_last_r  <= 1'b0;
      ret_pc_r    <= 32'h0000_0000;
      asm_r       <= 24'h00_0000;
      cnt_r       <= CNT_ZERO;
      inflight_r  <= CNT_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      fault_r     <= 1'b0;
    end else if (redirect) begin
      // Flush: the byte returning next cycle is dropped because ret_valid_r clears.
      fetch_pc_r  <= redirect_pc;
      byte_idx_r  <= 2'd0;
      mem_rd_r    <= 1'b0;
      iss_last_r  <= 1'b0;
      ret_valid_r <= 1'b0;
      ret_last_r  <= 1'b0;
      asm_r       <= 24'h00_0000;
      cnt_r       <= CNT_ZERO;
      inflight_r  <= CNT_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      fault_r     <= misaligned_s;
    end else begin
      mem_rd_r   <= issue_s;
      iss_last_r <= issue_s && (byte_idx_r == 2'd3);
      if (issue_s) begin
        mem_addr_r <= fetch_pc_r[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, byte_idx_r};
        byte_idx_r <= byte_idx_r + 2'd1;
        iss_pc_r   <= fetch_pc_r;
        if (byte_idx_r == 2'd3) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
      end
      ret_valid_r <= mem_rd_r;
      ret_last_r  <= iss_last_r;
      ret_pc_r    <= iss_pc_r;
      if (ret_valid_r) begin
        asm_r <= push_word_s[23:0];
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      case ({start_s, push_s})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // FIFO storage; contents are masked at the outputs so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_word_r[wr_ptr_r] <= push_word_s;
      fifo_pc_r[wr_ptr_r]   <= ret_pc_r;
    end
  end

  // Head presentation: zero whenever the FIFO is empty.
  always_comb begin
    inst    = 32'h0000_0000;
    inst_pc = 32'h0000_0000;
    if (cnt_r != CNT_ZERO) begin
      inst    = fifo_word_r[rd_ptr_r];
      inst_pc = fifo_pc_r[rd_ptr_r];
    end else begin
      inst    = 32'h0000_0000;
      inst_pc = 32'h0000_0000;
    end
  end

  assign mem_rd     = mem_rd_r;
  assign mem_addr   = mem_addr_r;
  assign inst_valid = (cnt_r != CNT_ZERO);
  assign fault      = fault_r;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed test-plan steps plus a randomized phase,
// with a transaction-level model of the expected byte-address and word streams.
module tb_imem_fetch_unit;

  localparam int          ADDR_W   = 5;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk;
  logic              reset;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              fault;

  logic [7:0]  mem [32];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_pc   = 32'h0;
  logic        halted   = 1'b0;

  imem_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous one-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [4:0] a0, a1, a2, a3;
    a0 = pc[4:0];
    a1 = a0 + 5'd1;
    a2 = a0 + 5'd2;
    a3 = a0 + 5'd3;
    return {mem[a0], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int budget, input string tag);
    int n = 0;
    while (!mem_rd && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_rd}, 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!inst_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic do_reset(input logic ready);
    reset      = 1'b1;
    redirect   = 1'b0;
    inst_ready = ready;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Stream monitor: byte addresses run sequentially from the fetch PC, delivered
  // words run PC, PC+4, ... with contents read big-endian from the memory image.
  always @(negedge clk) begin
    if (reset) begin
      exp_addr = RESET_PC[4:0];
      exp_pc   = RESET_PC;
      halted   = 1'b0;
    end else begin
      if (halted) begin
        chk("halt_rd", {31'd0, mem_rd}, 32'd0);
        chk("halt_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_fault", {31'd0, fault}, 32'd1);
      end else begin
        chk("fault_low", {31'd0, fault}, 32'd0);
      end
      if (mem_rd) begin
        chk("rd_addr", {27'd0, mem_addr}, {27'd0, exp_addr});
        exp_addr = exp_addr + 5'd1;
      end
      if (inst_valid && inst_ready && !redirect) begin
        chk("pop_pc", inst_pc, exp_pc);
        chk("pop_inst", inst, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        exp_addr = redirect_pc[4:0];
        exp_pc   = redirect_pc;
        halted   = (redirect_pc[1:0] != 2'b00);
      end
    end
  end

  initial begin
    int          r;
    logic [31:0] rp;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom());
    mem[0] = 8'h20; mem[1] = 8'h04; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h05; mem[6] = 8'h00; mem[7] = 8'h00;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b1;

    // Reset values
    tick(); tick(); tick();
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // 1: first-word latency and steady stream
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_rd", {31'd0, mem_rd}, 32'd1);
      chk("t1_addr", {27'd0, mem_addr}, 32'(i));
    end
    tick();
    chk("t1_not_yet", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst0", inst, 32'h20040005);
    chk("t1_pc0", inst_pc, 32'h0);
    tick(); tick(); tick();
    chk("t1_gap", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t1_valid1", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst1", inst, 32'h8C050000);
    chk("t1_pc1", inst_pc, 32'h4);

    // 2: full stall then drain in order
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_head", inst_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall", {31'd0, mem_rd}, 32'd0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("t2_second", inst_pc, 32'h4);
    wait_rd(4, "t2_resume");
    chk("t2_addr8", {27'd0, mem_addr}, 32'h8);

    // 3: redirect while word at pc 4 is mid-fetch
    do_reset(1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("t3_byte2", {27'd0, mem_addr}, 32'h6);
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    chk("t3_flushed", {31'd0, inst_valid}, 32'd0);
    wait_rd(4, "t3_rd");
    chk("t3_addr", {27'd0, mem_addr}, 32'h10);
    wait_valid(12, "t3_valid");
    chk("t3_pc", inst_pc, 32'h10);
    chk("t3_inst", inst, word_at(32'h10));

    // 4: end-of-memory wrap
    redirect = 1'b1; redirect_pc = 32'h1C;
    tick();
    redirect = 1'b0;
    wait_rd(4, "t4_rd");
    chk("t4_addr", {27'd0, mem_addr}, 32'h1C);
    tick(); tick(); tick();
    chk("t4_addr_last", {27'd0, mem_addr}, 32'h1F);
    tick();
    chk("t4_wrap_rd", {31'd0, mem_rd}, 32'd1);
    chk("t4_wrap_addr", {27'd0, mem_addr}, 32'h0);
    wait_valid(12, "t4_valid");
    chk("t4_pc", inst_pc, 32'h1C);
    chk("t4_inst", inst, word_at(32'h1C));
    tick();
    wait_valid(12, "t4_valid2");
    chk("t4_pc2", inst_pc, 32'h20);
    chk("t4_inst2", inst, 32'h20040005);

    // 5: misaligned redirect halts until an aligned one
    redirect = 1'b1; redirect_pc = 32'h06;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_fault", {31'd0, fault}, 32'd1);
      chk("t5_no_rd", {31'd0, mem_rd}, 32'd0);
      chk("t5_no_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h08;
    tick();
    redirect = 1'b0;
    chk("t5_fault_clr", {31'd0, fault}, 32'd0);
    wait_rd(3, "t5_rd");
    chk("t5_addr", {27'd0, mem_addr}, 32'h8);

    // 6a: redirect coinciding with a pop flushes both queued words
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_full", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect = 1'b0;
    chk("t6_flush", {31'd0, inst_valid}, 32'd0);
    wait_valid(12, "t6_valid");
    chk("t6_pc", inst_pc, 32'h14);

    // 6b: reset mid-word
    wait_rd(8, "t6_rd");
    tick();
    reset = 1'b1;
    tick();
    chk("t6r_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("t6r_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("t6r_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6r_inst", inst, 32'h0);
    chk("t6r_inst_pc", inst_pc, 32'h0);
    chk("t6r_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    tick();
    chk("t6r_restart_rd", {31'd0, mem_rd}, 32'd1);
    chk("t6r_restart_addr", {27'd0, mem_addr}, {27'd0, RESET_PC[4:0]});
    wait_valid(12, "t6r_valid");
    chk("t6r_pc", inst_pc, RESET_PC);
    chk("t6r_inst", inst, 32'h20040005);

    // 32-bit PC wrap, then randomized ready/redirect traffic
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    for (int c = 0; c < 600; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect   = 1'b0;
      r = $urandom_range(0, 49);
      if (r == 0 || (fault && r < 8)) begin
        redirect    = 1'b1;
        redirect_pc = $urandom() & 32'hFFFF_FFFC;
      end else if (r == 1) begin
        rp          = $urandom();
        redirect    = 1'b1;
        redirect_pc = {rp[31:2], (rp[1:0] == 2'b00) ? 2'b10 : rp[1:0]};
      end
      tick();
    end
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
